// File: rtl/spmv_row_engine_if.sv
// Stream bundle for spmv_row_engine: job control, row-pointer and nonzero inputs, x-read port, y results.
// master = job/memory side, slave = engine.
interface spmv_row_engine_if #(
    parameter int LENGTH      = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int PARALLELISM = 4,
    parameter int ACC_WIDTH   = 2 * DATA_WIDTH
);
    localparam int ADDR_WIDTH = $clog2(LENGTH);

    logic                              start;
    logic [ADDR_WIDTH:0]               num_rows;
    logic                              busy;
    logic                              done;
    logic                              err;
    logic                              rp_valid;
    logic                              rp_ready;
    logic [DATA_WIDTH-1:0]             rp_data;
    logic                              nz_valid;
    logic                              nz_ready;
    logic [PARALLELISM*DATA_WIDTH-1:0] nz_val;
    logic [PARALLELISM*ADDR_WIDTH-1:0] nz_col;
    logic                              x_req;
    logic [PARALLELISM*ADDR_WIDTH-1:0] x_addr;
    logic [PARALLELISM*DATA_WIDTH-1:0] x_rdata;
    logic                              y_valid;
    logic                              y_ready;
    logic [ADDR_WIDTH-1:0]             y_addr;
    logic [ACC_WIDTH-1:0]              y_data;

    modport master (
        output start, num_rows, rp_valid, rp_data, nz_valid, nz_val, nz_col, x_rdata, y_ready,
        input  busy, done, err, rp_ready, nz_ready, x_req, x_addr, y_valid, y_addr, y_data
    );

    modport slave (
        input  start, num_rows, rp_valid, rp_data, nz_valid, nz_val, nz_col, x_rdata, y_ready,
        output busy, done, err, rp_ready, nz_ready, x_req, x_addr, y_valid, y_addr, y_data
    );
endinterface

// File: rtl/spmv_row_engine.sv
// CSR sparse-row x dense-vector engine; define SPMV_SATURATE_EN to clamp sums instead of wrapping.
// Latency X_LAT+2 cycles from a row's last nz beat to y_valid; rp/nz stay stalled while y_valid && !y_ready.
module spmv_row_engine #(
    parameter int LENGTH      = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int PARALLELISM = 4,
    parameter int ACC_WIDTH   = 2 * DATA_WIDTH,
    parameter int X_LAT       = 2
) (
    input logic               clk,
    input logic               rst,
    spmv_row_engine_if.slave  bus
);
    localparam int ADDR_WIDTH = $clog2(LENGTH);
    localparam int AW  = ADDR_WIDTH;
    localparam int DW  = DATA_WIDTH;
    localparam int P   = PARALLELISM;
    localparam int PW  = 2 * DATA_WIDTH;
    localparam int DCW = $clog2(X_LAT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PTR0   = 3'd1;
    localparam logic [2:0] S_PTR    = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_WRITE  = 3'd5;

`ifdef SPMV_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

    logic [2:0]                  state;
    logic [AW:0]                 rows_q;
    logic [AW:0]                 row;
    logic signed [DW-1:0]        prev_ptr;
    logic [DW-1:0]               rem;
    logic [DCW-1:0]              drain_cnt;
    logic                        busy_q;
    logic                        done_q;
    logic                        err_q;

    logic [DW-1:0]               nnz;
    logic                        ptr_dec;
    logic                        nz_fire;
    logic                        row_clear;
    logic [P-1:0]                lane_mask;

    logic                        dl_vld  [X_LAT];
    logic [P-1:0]                dl_mask [X_LAT];
    logic [P*DW-1:0]             dl_val  [X_LAT];
    logic signed [PW-1:0]        prod_c  [P];
    logic signed [PW-1:0]        prod_q  [P];
    logic                        prod_vld;
    logic signed [ACC_WIDTH-1:0] acc     [P];
    logic signed [ACC_WIDTH-1:0] lane_sum;

    function automatic logic signed [ACC_WIDTH-1:0] acc_add(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [ACC_WIDTH-1:0] b
    );
`ifdef SPMV_SATURATE_EN
        logic signed [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
            return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        return s[ACC_WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    assign nnz       = bus.rp_data - prev_ptr;
    assign ptr_dec   = $signed(bus.rp_data) < prev_ptr;
    assign nz_fire   = (state == S_STREAM) && bus.nz_valid;
    assign row_clear = (state == S_PTR) && bus.rp_valid;

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < P; i++)
            lane_mask[i] = DW'(i) < rem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rows_q    <= '0;
            row       <= '0;
            prev_ptr  <= '0;
            rem       <= '0;
            drain_cnt <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) begin
                    rows_q <= bus.num_rows;
                    row    <= '0;
                    err_q  <= 1'b0;
                    if (bus.num_rows == '0) begin
                        done_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b1;
                        state  <= S_PTR0;
                    end
                end
                S_PTR0: if (bus.rp_valid) begin
                    prev_ptr <= bus.rp_data;
                    state    <= S_PTR;
                end
                S_PTR: if (bus.rp_valid) begin
                    prev_ptr <= bus.rp_data;
                    // A decreasing pointer is flagged and the row is emitted as empty.
                    if (ptr_dec)
                        err_q <= 1'b1;
                    if (ptr_dec || nnz == '0) begin
                        state <= S_WRITE;
                    end else begin
                        rem   <= nnz;
                        state <= S_STREAM;
                    end
                end
                S_STREAM: if (bus.nz_valid) begin
                    if (rem <= DW'(P)) begin
                        drain_cnt <= DCW'(X_LAT);
                        state     <= S_DRAIN;
                    end else begin
                        rem <= rem - DW'(P);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == '0)
                        state <= S_WRITE;
                    else
                        drain_cnt <= drain_cnt - 1'b1;
                end
                S_WRITE: if (bus.y_ready) begin
                    if (row + 1'b1 == rows_q) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        row   <= row + 1'b1;
                        state <= S_PTR;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Product of the lane value (delayed to meet x_rdata) with x; masked lanes give 0.
    always_comb begin
        for (int i = 0; i < P; i++) begin
            prod_c[i] = '0;
            if (dl_vld[X_LAT-1] && dl_mask[X_LAT-1][i])
                prod_c[i] = PW'($signed(dl_val[X_LAT-1][i*DW +: DW]))
                          * PW'($signed(bus.x_rdata[i*DW +: DW]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < X_LAT; k++) begin
                dl_vld[k]  <= 1'b0;
                dl_mask[k] <= '0;
                dl_val[k]  <= '0;
            end
            for (int i = 0; i < P; i++) begin
                prod_q[i] <= '0;
                acc[i]    <= '0;
            end
            prod_vld <= 1'b0;
        end else begin
            dl_vld[0]  <= nz_fire;
            dl_mask[0] <= lane_mask;
            dl_val[0]  <= bus.nz_val;
            for (int k = 1; k < X_LAT; k++) begin
                dl_vld[k]  <= dl_vld[k-1];
                dl_mask[k] <= dl_mask[k-1];
                dl_val[k]  <= dl_val[k-1];
            end
            prod_vld <= dl_vld[X_LAT-1];
            for (int i = 0; i < P; i++) begin
                prod_q[i] <= prod_c[i];
                if (row_clear)
                    acc[i] <= '0;
                else if (prod_vld)
                    acc[i] <= acc_add(acc[i], ACC_WIDTH'(prod_q[i]));
            end
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < P; i++)
            lane_sum = acc_add(lane_sum, acc[i]);
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.rp_ready = (state == S_PTR0) || (state == S_PTR);
    assign bus.nz_ready = (state == S_STREAM);
    assign bus.x_req    = nz_fire;
    assign bus.x_addr   = nz_fire ? bus.nz_col : '0;
    assign bus.y_valid  = (state == S_WRITE);
    assign bus.y_addr   = (state == S_WRITE) ? row[AW-1:0] : '0;
    assign bus.y_data   = (state == S_WRITE) ? lane_sum : '0;
endmodule

// File: tb/tb_spmv_row_engine.sv
// Directed bench for spmv_row_engine (DATA_WIDTH=8, ACC_WIDTH=16, P=4, X_LAT=2) with a 2-cycle x memory model.
module tb_spmv_row_engine;
    localparam int LENGTH = 32;
    localparam int DW     = 8;
    localparam int P      = 4;
    localparam int ACC    = 16;
    localparam int XL     = 2;
    localparam int AW     = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spmv_row_engine_if #(.LENGTH(LENGTH), .DATA_WIDTH(DW), .PARALLELISM(P), .ACC_WIDTH(ACC)) bus ();

    spmv_row_engine #(
        .LENGTH(LENGTH), .DATA_WIDTH(DW), .PARALLELISM(P), .ACC_WIDTH(ACC), .X_LAT(XL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // x memory: data appears exactly XL=2 cycles after the request
    logic [DW-1:0]   xmem [LENGTH];
    logic [P*DW-1:0] xrd_c, xs1, xs2;
    always_comb begin
        xrd_c = '0;
        for (int i = 0; i < P; i++)
            xrd_c[i*DW +: DW] = xmem[bus.x_addr[i*AW +: AW]];
    end
    always @(posedge clk) begin
        xs1 <= xrd_c;
        xs2 <= xs1;
    end
    assign bus.x_rdata = xs2;

    int n_vec = 0;
    int n_bad = 0;

    logic [DW-1:0]   rp_q  [$];
    logic [P*DW-1:0] nzv_q [$];
    logic [P*AW-1:0] nzc_q [$];
    logic [AW-1:0]   ya_q  [$];
    logic [ACC-1:0]  yd_q  [$];
    logic            rp_f, nz_f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [7:0] v0, v1, v2, v3, input logic [4:0] c0, c1, c2, c3);
        nzv_q.push_back({v3, v2, v1, v0});
        nzc_q.push_back({c3, c2, c1, c0});
    endtask

    task automatic drive_streams();
        bus.rp_valid = (rp_q.size() != 0);
        bus.rp_data  = bus.rp_valid ? rp_q[0] : '0;
        bus.nz_valid = (nzv_q.size() != 0);
        bus.nz_val   = bus.nz_valid ? nzv_q[0] : '0;
        bus.nz_col   = bus.nz_valid ? nzc_q[0] : '0;
    endtask

    task automatic clear_streams();
        rp_q.delete();
        nzv_q.delete();
        nzc_q.delete();
        drive_streams();
    endtask

    // Runs one job; with stall>0, y_ready is held low for that many cycles of the first WRITE.
    task automatic run_job(input int rows, input int stall);
        int stall_left;
        bit seen_y, fin;
        logic [AW-1:0]  sa;
        logic [ACC-1:0] sd;
        stall_left = stall;
        seen_y = 0;
        fin = 0;
        sa = '0;
        sd = '0;
        ya_q.delete();
        yd_q.delete();
        drive_streams();
        bus.y_ready  = (stall == 0);
        bus.num_rows = rows[AW:0];
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(negedge clk);
            rp_f = bus.rp_valid && bus.rp_ready;
            nz_f = bus.nz_valid && bus.nz_ready;
            if (bus.done) fin = 1;
            if (bus.y_valid && bus.y_ready) begin
                ya_q.push_back(bus.y_addr);
                yd_q.push_back(bus.y_data);
            end
            if (bus.y_valid && stall_left > 0) begin
                if (seen_y) begin
                    check("stall_y_addr", bus.y_addr, sa);
                    check("stall_y_data", bus.y_data, sd);
                    check("stall_rp_ready", bus.rp_ready, 0);
                    check("stall_nz_ready", bus.nz_ready, 0);
                end
                seen_y = 1;
                sa = bus.y_addr;
                sd = bus.y_data;
                stall_left--;
            end
            @(posedge clk); #1;
            if (rp_f) void'(rp_q.pop_front());
            if (nz_f) begin
                void'(nzv_q.pop_front());
                void'(nzc_q.pop_front());
            end
            drive_streams();
            if (stall_left == 0) bus.y_ready = 1'b1;
        end
        if (!fin) check("job_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.num_rows = '0;
        bus.y_ready = 1'b0;
        for (int i = 0; i < LENGTH; i++) xmem[i] = '0;
        clear_streams();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_y_valid", bus.y_valid, 0);
        check("rst_rp_ready", bus.rp_ready, 0);
        check("rst_nz_ready", bus.nz_ready, 0);
        check("rst_x_req", bus.x_req, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // dense row: 1+2+3+4
        xmem[0] = 8'd1; xmem[1] = 8'd2; xmem[2] = 8'd3; xmem[3] = 8'd4;
        rp_q = '{8'd0, 8'd4};
        push_beat(1, 1, 1, 1, 0, 1, 2, 3);
        run_job(1, 0);
        check("dense_count", ya_q.size(), 1);
        check("dense_addr", ya_q[0], 0);
        check("dense_data", yd_q[0], 10);
        check("dense_done_once", bus.done, 0);
        check("dense_busy_off", bus.busy, 0);
        check("dense_err", bus.err, 0);

        // rows 0 and 2 empty; row 1 has 5 nonzeros, second beat masks lanes 1-3
        xmem[4] = 8'd5; xmem[5] = 8'd7; xmem[6] = 8'd7; xmem[7] = 8'd7;
        rp_q = '{8'd0, 8'd0, 8'd5, 8'd5};
        push_beat(1, 2, 3, 4, 0, 1, 2, 3);
        push_beat(5, 9, 9, 9, 4, 5, 6, 7);
        run_job(3, 0);
        check("multi_count", ya_q.size(), 3);
        check("multi_addr0", ya_q[0], 0);
        check("multi_data0", yd_q[0], 0);
        check("multi_addr1", ya_q[1], 1);
        check("multi_data1", yd_q[1], 55);
        check("multi_addr2", ya_q[2], 2);
        check("multi_data2", yd_q[2], 0);
        check("multi_beats_used", nzv_q.size(), 0);

        // decreasing pointers: flagged, empty row, no beat taken
        clear_streams();
        rp_q = '{8'd3, 8'd1};
        push_beat(9, 9, 9, 9, 0, 1, 2, 3);
        run_job(1, 0);
        check("dec_count", ya_q.size(), 1);
        check("dec_data", yd_q[0], 0);
        check("dec_err", bus.err, 1);
        check("dec_beat_kept", nzv_q.size(), 1);

        // y_ready stalled 5 cycles: 2*1 + 3*2
        clear_streams();
        rp_q = '{8'd0, 8'd2, 8'd9};
        push_beat(2, 3, 100, 100, 0, 1, 2, 3);
        push_beat(50, 50, 50, 50, 0, 1, 2, 3);
        run_job(1, 5);
        check("stall_count", ya_q.size(), 1);
        check("stall_data", yd_q[0], 8);
        check("stall_err_cleared", bus.err, 0);
        check("stall_rp_left", rp_q.size(), 1);
        check("stall_nz_left", nzv_q.size(), 1);

        // signed mix: (-3)(-2) + 5*4 + 2*(-100) = -174
        clear_streams();
        xmem[12] = 8'hFE; xmem[13] = 8'd4; xmem[14] = 8'h9C;
        rp_q = '{8'd0, 8'd3};
        push_beat(8'hFD, 5, 2, 77, 12, 13, 14, 3);
        run_job(1, 0);
        check("signed_data", yd_q[0], 16'hFF52);

        // four 127*127 products overflow 16 bits
        xmem[8] = 8'd127; xmem[9] = 8'd127; xmem[10] = 8'd127; xmem[11] = 8'd127;
        rp_q = '{8'd0, 8'd4};
        push_beat(127, 127, 127, 127, 8, 9, 10, 11);
        run_job(1, 0);
`ifdef SPMV_SATURATE_EN
        check("ovf_data", yd_q[0], 16'h7FFF);
`else
        check("ovf_data", yd_q[0], 16'hFC04);
`endif

        // zero-row job finishes immediately
        bus.num_rows = '0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("zero_done", bus.done, 1);
        check("zero_busy", bus.busy, 0);
        @(posedge clk); #1;
        check("zero_done_pulse", bus.done, 0);

        // reset while waiting in STREAM, then a clean job
        clear_streams();
        rp_q = '{8'd0, 8'd4};
        drive_streams();
        bus.num_rows = 6'd2;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 0; c < 20 && !bus.nz_ready; c++) begin
            @(negedge clk);
            rp_f = bus.rp_valid && bus.rp_ready;
            @(posedge clk); #1;
            if (rp_f) void'(rp_q.pop_front());
            drive_streams();
        end
        check("abort_in_stream", bus.nz_ready, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_err", bus.err, 0);
        check("abort_y_valid", bus.y_valid, 0);
        check("abort_y_data", bus.y_data, 0);
        check("abort_y_addr", bus.y_addr, 0);
        check("abort_rp_ready", bus.rp_ready, 0);
        check("abort_nz_ready", bus.nz_ready, 0);
        check("abort_x_req", bus.x_req, 0);
        check("abort_x_addr", bus.x_addr, 0);
        clear_streams();
        rp_q = '{8'd0, 8'd4};
        push_beat(1, 1, 1, 1, 0, 1, 2, 3);
        run_job(1, 0);
        check("rerun_count", ya_q.size(), 1);
        check("rerun_addr", ya_q[0], 0);
        check("rerun_data", yd_q[0], 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/spmv_row_engine.md
SPMV_ROW_ENGINE -- requirements
Module: spmv_row_engine

Interface
REQ-001 SHALL take parameter LENGTH, default 32, meaning vector length; ADDR_WIDTH = $clog2(LENGTH).
REQ-002 SHALL take parameter DATA_WIDTH, default 32, meaning signed integer width of values, x entries and row pointers.
REQ-003 SHALL take parameter PARALLELISM, default 4, meaning nonzero lanes per beat (P).
REQ-004 SHALL take parameter ACC_WIDTH, default 2*DATA_WIDTH, meaning accumulator and y width (>= 2*DATA_WIDTH).
REQ-005 SHALL take parameter X_LAT, default 2, meaning fixed x read latency in cycles (>= 1).
REQ-006 SHALL have these ports; one clock; reset is synchronous and active-high.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  pulse, begins a job when IDLE
- num_rows  in  ADDR_WIDTH+1  rows in job, sampled on start
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky decreasing-pointer flag, cleared on start
- rp_valid / rp_ready / rp_data  in / out / DATA_WIDTH  row-pointer stream
- nz_valid / nz_ready  in / out  1  nonzero beat handshake
- nz_val  in  P*DATA_WIDTH  values, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- nz_col  in  P*ADDR_WIDTH  column indices, packed likewise
- x_req  out  1  x read strobe, no backpressure
- x_addr  out  P*ADDR_WIDTH  x read addresses
- x_rdata  in  P*DATA_WIDTH  x data, valid exactly X_LAT cycles after x_req
- y_valid / y_ready  out / in  1  result handshake
- y_addr  out  ADDR_WIDTH  row index
- y_data  out  ACC_WIDTH  row result

Function
REQ-007 SHALL implement states IDLE, PTR0, PTR, STREAM, DRAIN, WRITE.
REQ-008 SHALL in IDLE on start latch num_rows, clear err and row index, assert busy, go to PTR0; num_rows==0 SHALL go straight to IDLE pulsing done next cycle.
REQ-009 SHALL in PTR0 accept one rp beat (rp_ready=1) as base pointer, then go to PTR.
REQ-010 SHALL in PTR accept one rp beat, set nnz = rp_data - previous pointer, store rp_data as previous, go to STREAM (nnz>0) or WRITE (nnz==0).
REQ-011 SHALL, if rp_data < previous pointer (signed), treat nnz as 0 and set err.
REQ-012 SHALL in STREAM consume ceil(nnz/P) beats; each row starts on a fresh beat; lane i of a beat is active iff i < remaining nnz; inactive lanes contribute 0.
REQ-013 SHALL drive nz_ready only in STREAM and assert x_req with x_addr=nz_col in the same cycle as each nz handshake.
REQ-014 SHALL delay nz_val and lane masks X_LAT cycles, form signed products with x_rdata, register them one cycle, then add sign-extended into P lane accumulators cleared at row start.
REQ-015 SHALL after the last beat enter DRAIN for X_LAT+1 cycles, then WRITE.
REQ-016 SHALL in WRITE hold y_valid=1, y_addr=row index, y_data=sum of lane accumulators until y_ready; then increment row, go to PTR, or if last row go to IDLE, drop busy, pulse done.
REQ-017 SHALL wrap all sums modulo 2^ACC_WIDTH unless REQ-021 applies.
REQ-018 SHALL keep y_data and y_addr stable while y_valid && !y_ready.
REQ-019 SHALL ignore start while busy.

Reset
REQ-020 SHALL on rst go to IDLE and drive busy, done, err, rp_ready, nz_ready, x_req, y_valid to 0, clear accumulators and delay-line valids; reset mid-job SHALL discard the job with no y write.

Configuration
REQ-021 SHALL, when SPMV_SATURATE_EN is defined, clamp each accumulate and the lane sum to signed ACC_WIDTH min/max; when undefined, wrap per REQ-017.

Verification
REQ-022 Dense 1 row, nnz=4, P=4, x=[1,2,3,4], vals=[1,1,1,1] -> one beat, y_addr=0, y_data=10, done once.
REQ-023 Pointers [0,0,5,5], 3 rows -> y=0 for rows 0 and 2; row 1 takes 2 beats, lanes 1-3 of beat 2 masked.
REQ-024 Pointers [3,1] -> err=1, y_data=0 for row 0, done pulses.
REQ-025 y_ready low 5 cycles during WRITE -> y_valid, y_addr, y_data stable; no rp or nz beats consumed.
REQ-026 DATA_WIDTH=8, ACC_WIDTH=16, four products 127*127 -> 64516 wraps to -1020; with SPMV_SATURATE_EN -> 32767.
REQ-027 rst asserted during STREAM -> next cycle busy=0, all outputs 0; fresh start then completes correctly.
